// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing one X-bus between three masters (0 = cpu, 1 = dma, 2 = spy).
// Define XBUS_TIMEOUT_EN to abort transactions whose address stays undecoded in WAIT.
module xbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  input  logic        m2_req,
  input  logic        m2_write,
  input  logic [21:0] m2_addr,
  input  logic [31:0] m2_wdata,
  output logic        m2_ack,
  output logic        m2_err,
  output logic [31:0] rdata,
  output logic        xb_req,
  output logic        xb_write,
  output logic [21:0] xb_addr,
  output logic [31:0] xb_dataout,
  input  logic [31:0] xb_datain,
  input  logic        xb_ack,
  input  logic        xb_decode,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RELEASE} state_t;

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  state_t           state, state_next;
  logic [1:0]       last_grant;
  logic [1:0]       winner, cand;
  logic             win_valid;
  logic [2:0]       reqs;
  logic             sel_write;
  logic [21:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [REL_W-1:0] rel_cnt;
  logic             rel_done;
  logic             ack_event, to_event;
  logic [2:0]       ack_q, err_q;

  assign reqs = {m2_req, m1_req, m0_req};

  // Search starts one past the last-granted index, so the previous owner is considered last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner    = 2'd0;
    win_valid = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_grant) + k) % 3);
      if (!win_valid && reqs[cand]) begin
        winner    = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_write = m0_write;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    case (winner)
      2'd1: begin
        sel_write = m1_write;
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
      end
      2'd2: begin
        sel_write = m2_write;
        sel_addr  = m2_addr;
        sel_wdata = m2_wdata;
      end
      default: ;
    endcase
  end

  assign ack_event = ((state == REQ) || (state == WAIT)) && xb_ack;
  assign rel_done  = (state == RELEASE) && (rel_cnt == REL_W'(RELEASE_CYCLES - 1));

`ifdef XBUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // A slave ack in the same cycle as the final undecoded cycle still completes normally.
  assign to_event = (state == WAIT) && !xb_ack && !xb_decode &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        to_cnt <= '0;
    else if (state == WAIT && !xb_decode) to_cnt <= to_cnt + TO_W'(1);
    else                                  to_cnt <= '0;
  end
`else
  logic [31:0] unused_cfg;
  assign to_event   = 1'b0;
  assign unused_cfg = {xb_decode, 31'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid) state_next = REQ;
      REQ:     state_next = (ack_event || to_event) ? RELEASE : WAIT;
      WAIT:    if (ack_event || to_event) state_next = RELEASE;
      RELEASE: if (rel_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xb_req     <= 1'b0;
      xb_write   <= 1'b0;
      xb_addr    <= '0;
      xb_dataout <= '0;
      rdata      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      grant      <= 2'd3;
      last_grant <= 2'd2;
      rel_cnt    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: if (win_valid) begin
          grant      <= winner;
          last_grant <= winner;
          xb_req     <= 1'b1;
          xb_write   <= sel_write;
          xb_addr    <= sel_addr;
          xb_dataout <= sel_wdata;
        end
        REQ, WAIT: if (ack_event || to_event) begin
          xb_req <= 1'b0;
          rdata  <= ack_event ? xb_datain : 32'h0;
          ack_q  <= 3'b001 << grant;
          err_q  <= to_event ? (3'b001 << grant) : 3'b000;
        end
        RELEASE: begin
          if (rel_done) begin
            grant   <= 2'd3;
            rel_cnt <= '0;
          end else begin
            rel_cnt <= rel_cnt + REL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign {m2_ack, m1_ack, m0_ack} = ack_q;
  assign {m2_err, m1_err, m0_err} = err_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: directed transaction table, multi-cycle corner cases,
// and randomized traffic compared against a cycle-level ownership model.
module tb_xbus_arbiter;

  localparam int TB_REL = 3;
  localparam int TB_TO  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  m_req, m_write;
  logic [21:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  wire  [2:0]  m_ack, m_err;
  wire  [31:0] rdata, xb_dataout;
  wire         xb_req, xb_write, busy;
  wire  [21:0] xb_addr;
  wire  [1:0]  grant;
  logic [31:0] xb_datain;
  logic        xb_ack, xb_decode;

  int n_cmp  = 0;
  int n_fail = 0;

  xbus_arbiter #(.TIMEOUT_CYCLES(TB_TO), .RELEASE_CYCLES(TB_REL)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m_req[0]), .m0_write(m_write[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_ack(m_ack[0]), .m0_err(m_err[0]),
    .m1_req(m_req[1]), .m1_write(m_write[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_ack(m_ack[1]), .m1_err(m_err[1]),
    .m2_req(m_req[2]), .m2_write(m_write[2]), .m2_addr(m_addr[2]), .m2_wdata(m_wdata[2]),
    .m2_ack(m_ack[2]), .m2_err(m_err[2]),
    .rdata(rdata), .xb_req(xb_req), .xb_write(xb_write), .xb_addr(xb_addr),
    .xb_dataout(xb_dataout), .xb_datain(xb_datain), .xb_ack(xb_ack), .xb_decode(xb_decode),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [1:0] g, input logic b, input logic rq,
                                        input logic w, input logic [21:0] a, input logic [31:0] d,
                                        input logic [31:0] rd, input logic [2:0] ak, input logic [2:0] er);
    return {31'b0, g, b, rq, w, a, d, rd, ak, er};
  endfunction

  function automatic logic [127:0] outs();
    return pack(grant, busy, xb_req, xb_write, xb_addr, xb_dataout, rdata, m_ack, m_err);
  endfunction

  function automatic logic [127:0] reset_vec();
    return pack(2'd3, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 3'b0, 3'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req     = '0;
    m_write   = '0;
    xb_ack    = 1'b0;
    xb_datain = '0;
    xb_decode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_addr[i]  = '0;
      m_wdata[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check("reset", outs(), reset_vec());
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  // ---------------- directed transaction table ----------------
  typedef struct {
    int          master;
    logic        write;
    logic [21:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    int          ack_hold;
    logic [31:0] datain;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_txn(input vec_t v);
    int m = v.master;
    m_req[m]   = 1'b1;
    m_write[m] = v.write;
    m_addr[m]  = v.addr;
    m_wdata[m] = v.wdata;
    tick();
    check("issue", {grant, xb_req, xb_write, xb_addr, xb_dataout, m_ack},
          {2'(m), 1'b1, v.write, v.addr, v.wdata, 3'b000});
    // Requester drops and scrambles its inputs; the bus side must not follow.
    m_req[m]   = 1'b0;
    m_addr[m]  = 22'($urandom);
    m_wdata[m] = $urandom;
    m_write[m] = ~v.write;
    for (int i = 0; i < v.ack_delay; i++) begin
      tick();
      check("hold", {grant, xb_req, xb_write, xb_addr, xb_dataout, m_ack},
            {2'(m), 1'b1, v.write, v.addr, v.wdata, 3'b000});
    end
    xb_ack    = 1'b1;
    xb_datain = v.datain;
    tick();
    check("done", {m_ack, m_err, rdata, xb_req}, {3'b001 << m, 3'b000, v.exp_rdata, 1'b0});
    xb_datain = ~v.datain;
    for (int r = 1; r <= TB_REL; r++) begin
      if (r > v.ack_hold) xb_ack = 1'b0;
      tick();
      check("release", {m_ack, grant, busy, xb_req, rdata},
            {3'b000, (r == TB_REL) ? 2'd3 : 2'(m), r != TB_REL, 1'b0, v.exp_rdata});
    end
    xb_ack = 1'b0;
    tick();
    check("idle_after", {m_ack, grant, busy, xb_req}, {3'b000, 2'd3, 1'b0, 1'b0});
  endtask

  // ---------------- round robin with all masters requesting ----------------
  task automatic rr_test();
    int got[$];
    int rise_t[$];
    int exp_order[4] = '{0, 1, 2, 0};
    int age = 0;
    logic prev = 1'b0;
    do_reset();
    m_req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      m_addr[i]  = 22'(i + 1);
      m_wdata[i] = 32'(i);
    end
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      tick();
      if (xb_req && !prev) begin
        got.push_back(int'(grant));
        rise_t.push_back(c);
      end
      prev      = xb_req;
      age       = xb_req ? age + 1 : 0;
      xb_ack    = xb_req && (age == 2);
      xb_datain = 32'(c);
    end
    m_req = '0;
    for (int c = 0; c < 20 && busy; c++) begin
      tick();
      age    = xb_req ? age + 1 : 0;
      xb_ack = xb_req && (age == 2);
    end
    xb_ack = 1'b0;
    check("rr_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("rr_grant", got[i], exp_order[i]);
    for (int i = 1; i < rise_t.size(); i++)
      check("rr_spacing", rise_t[i] - rise_t[i-1], 3 + TB_REL);
    wait_idle("rr_drain", 10);
  endtask

  // ---------------- reset in the middle of WAIT ----------------
  task automatic reset_wait_test();
    m_req[0]   = 1'b1;
    m_write[0] = 1'b0;
    m_addr[0]  = 22'h1234;
    tick();
    m_req[0] = 1'b0;
    tick();
    tick();
    check("pre_reset", {busy, xb_req, grant}, {1'b1, 1'b1, 2'd0});
    #2;
    reset_n = 1'b0;
    xb_ack  = 1'b1;
    xb_datain = 32'hFFFF_0000;
    #1;
    check("reset_async", outs(), reset_vec());
    tick();
    check("reset_hold", outs(), reset_vec());
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("reset_no_ack", outs(), reset_vec());
    xb_ack = 1'b0;
  endtask

  // ---------------- undecoded address ----------------
  task automatic timeout_test();
    xb_decode  = 1'b0;
    m_req[0]   = 1'b1;
    m_write[0] = 1'b0;
    m_addr[0]  = 22'h3F0000;
    tick();
    m_req[0] = 1'b0;
    check("to_issue", {grant, xb_req}, {2'd0, 1'b1});
`ifdef XBUS_TIMEOUT_EN
    for (int i = 0; i < TB_TO; i++) begin
      tick();
      check("to_wait", {m_ack, m_err, busy, xb_req}, {3'b000, 3'b000, 1'b1, 1'b1});
    end
    tick();
    check("to_abort", {m_ack, m_err, rdata, xb_req}, {3'b001, 3'b001, 32'h0, 1'b0});
    xb_decode = 1'b1;
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("no_to_wait", {m_ack, m_err, busy, xb_req}, {3'b000, 3'b000, 1'b1, 1'b1});
    end
    xb_decode = 1'b1;
    xb_ack    = 1'b1;
    xb_datain = 32'h0BAD_0BAD;
    tick();
    xb_ack = 1'b0;
    check("no_to_ack", {m_ack, m_err, rdata}, {3'b001, 3'b000, 32'h0BAD_0BAD});
`endif
    wait_idle("to_drain", 10);
  endtask

  // ---------------- reference model: who owns the bus and for how long ----------------
  int          mo_owner, mo_last, mo_age, mo_rel, mo_undec;
  logic        mo_inflight, mo_write;
  logic [21:0] mo_addr;
  logic [31:0] mo_wdata, mo_rdata;
  logic [2:0]  mo_ack, mo_err;

  task automatic model_reset();
    mo_owner = -1; mo_last = 2; mo_age = 0; mo_rel = 0; mo_undec = 0;
    mo_inflight = 1'b0; mo_write = 1'b0; mo_addr = '0; mo_wdata = '0; mo_rdata = '0;
    mo_ack = '0; mo_err = '0;
  endtask

  task automatic model_step();
    bit finish = 0;
    bit abort  = 0;
    int c;
    mo_ack = '0;
    mo_err = '0;
    if (mo_inflight) begin
      if (xb_ack) begin
        finish   = 1;
        mo_rdata = xb_datain;
      end else begin
`ifdef XBUS_TIMEOUT_EN
        if (mo_age >= 1) begin
          mo_undec = xb_decode ? 0 : mo_undec + 1;
          if (mo_undec == TB_TO) begin
            finish   = 1;
            abort    = 1;
            mo_rdata = '0;
          end
        end
`endif
      end
      if (finish) begin
        mo_ack[mo_owner] = 1'b1;
        if (abort) mo_err[mo_owner] = 1'b1;
        mo_inflight = 1'b0;
        mo_rel      = TB_REL;
      end
      mo_age++;
    end else if (mo_rel > 0) begin
      mo_rel--;
      if (mo_rel == 0) mo_owner = -1;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        c = (mo_last + k) % 3;
        if (mo_owner < 0 && m_req[c]) begin
          mo_owner = c; mo_last = c; mo_age = 0; mo_undec = 0; mo_inflight = 1'b1;
          mo_write = m_write[c]; mo_addr = m_addr[c]; mo_wdata = m_wdata[c];
        end
      end
    end
  endtask

  function automatic logic [127:0] model_vec();
    return pack((mo_owner < 0) ? 2'd3 : 2'(mo_owner), mo_owner >= 0, mo_inflight, mo_write,
                mo_addr, mo_wdata, mo_rdata, mo_ack, mo_err);
  endfunction

  task automatic random_test(input int cycles);
    bit dec_lo;
    do_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      dec_lo = ((c / 500) % 2) == 1;
      for (int i = 0; i < 3; i++) begin
        m_req[i]   = ($urandom_range(0, 2) != 0);
        m_write[i] = 1'($urandom);
        m_addr[i]  = 22'($urandom);
        m_wdata[i] = $urandom;
      end
      xb_ack    = ($urandom_range(0, 4) == 0);
      xb_datain = $urandom;
      xb_decode = dec_lo ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      model_step();
      tick();
      check("rand", outs(), model_vec());
      check("one_ack", $countones(m_ack) <= 1, 1'b1);
    end
    clear_inputs();
  endtask

  initial begin
    vecs[0] = '{1, 1'b0, 22'o17766001, 32'h0,         3, 0, 32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{2, 1'b1, 22'o17766010, 32'hDEAD_BEEF, 2, 0, 32'h0000_0042, 32'h0000_0042};
    vecs[2] = '{0, 1'b0, 22'h3F_FFFF,  32'h0,         0, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[3] = '{1, 1'b1, 22'h00_0000,  32'hFFFF_FFFF, 1, 3, 32'h1357_9BDF, 32'h1357_9BDF};
    vecs[4] = '{0, 1'b1, 22'h2A_AAAA,  32'h0000_0001, 5, 1, 32'hCAFE_F00D, 32'hCAFE_F00D};

    reset_n = 1'b0;
    clear_inputs();
    do_reset();
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
    rr_test();
    reset_wait_test();
    run_txn(vecs[0]);
    timeout_test();
    random_test(2500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
